// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer.
package fetch_pkg;

   localparam logic [31:0] FETCH_RESET_PC = 32'hbfc00000;
   localparam int unsigned FETCH_STEP1    = 32'd4;
   localparam int unsigned FETCH_STEP2    = 32'd8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      RESP  = 2'd2,
      STALE = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_seq_ctrl_redirect_sel.sv
// Fixed-priority redirect selector: exception beats branch beats full flush.
module redirect_sel
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              is_except_i,
   input  logic [ADDR_W-1:0] except_addr_i,
   input  logic              branch_en_i,
   input  logic              branch_taken_i,
   input  logic [ADDR_W-1:0] branch_addr_i,
   input  logic              flush_all_i,
   input  logic [ADDR_W-1:0] flush_all_addr_i,
   output logic              redir_o,
   output logic [ADDR_W-1:0] redir_tgt_o
);

   logic branch_redir_s;

   assign branch_redir_s = branch_en_i & branch_taken_i;

   // Priority mux over the three redirect sources
   always_comb begin
      redir_o     = is_except_i | branch_redir_s | flush_all_i;
      redir_tgt_o = {ADDR_W{1'b0}};
      if (is_except_i) begin
         redir_tgt_o = except_addr_i;
      end else if (branch_redir_s) begin
         redir_tgt_o = branch_addr_i;
      end else if (flush_all_i) begin
         redir_tgt_o = flush_all_addr_i;
      end else begin
         redir_tgt_o = {ADDR_W{1'b0}};
      end
   end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// IF-stage sequencer: owns the fetch PC, drives the inst bus, squashes stale
// responses after a redirect and hands 1 or 2 instructions to the inst FIFO.
module fetch_seq_ctrl
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              is_except,
   input  logic [ADDR_W-1:0] except_addr,
   input  logic              branch_en,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_addr,
   input  logic              flush_all,
   input  logic [ADDR_W-1:0] flush_all_addr,
   input  logic              fifo_full,
   output logic              inst_req,
   output logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_addr_ok,
   input  logic              inst_data_ok,
   input  logic [ADDR_W-1:0] inst_rdata1,
   input  logic [ADDR_W-1:0] inst_rdata2,
   output logic              fetch_valid1,
   output logic              fetch_valid2,
   output logic [ADDR_W-1:0] fetch_inst1,
   output logic [ADDR_W-1:0] fetch_inst2,
   output logic [ADDR_W-1:0] fetch_pc,
   output logic [ADDR_W-1:0] pc_curr,
   output logic              redirect_pend
);

   localparam logic [ADDR_W-1:0] STEP1 = ADDR_W'(FETCH_STEP1);
   localparam logic [ADDR_W-1:0] STEP2 = ADDR_W'(FETCH_STEP2);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] req_addr_q, req_addr_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
   logic              pend_q, pend_d;

   logic              redir_s;
   logic [ADDR_W-1:0] redir_tgt_s;
   logic [ADDR_W-1:0] nxt_pc_s;
   logic              fv1_s, fv2_s;

   redirect_sel #(.ADDR_W(ADDR_W)) u_redirect_sel (
      .is_except_i      (is_except),
      .except_addr_i    (except_addr),
      .branch_en_i      (branch_en),
      .branch_taken_i   (branch_taken),
      .branch_addr_i    (branch_addr),
      .flush_all_i      (flush_all),
      .flush_all_addr_i (flush_all_addr),
      .redir_o          (redir_s),
      .redir_tgt_o      (redir_tgt_s)
   );

   // An odd-word start only yields one valid slot, so advance by 4 instead of 8
   assign nxt_pc_s = req_addr_q + (req_addr_q[2] ? STEP1 : STEP2);

   // Next-state, PC and pending-redirect logic
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      pend_d     = pend_q;
      pend_pc_d  = pend_pc_q;
      fv1_s      = 1'b0;
      fv2_s      = 1'b0;
      case (state_q)
         IDLE: begin
            if (redir_s) begin
               pc_d = redir_tgt_s;
            end else if (pend_q) begin
               pc_d   = pend_pc_q;
               pend_d = 1'b0;
            end else if (!fifo_full) begin
               req_addr_d = pc_q;
               state_d    = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (redir_s) begin
               pend_pc_d = redir_tgt_s;
               pend_d    = 1'b1;
            end else begin
               pend_d = pend_q;
            end
            if (inst_addr_ok) begin
               state_d = (pend_q | redir_s) ? STALE : RESP;
            end else begin
               state_d = REQ;
            end
         end
         RESP: begin
            if (inst_data_ok && redir_s) begin
               pc_d    = redir_tgt_s;
               state_d = IDLE;
            end else if (inst_data_ok) begin
               fv1_s = 1'b1;
               fv2_s = ~req_addr_q[2];
               pc_d  = nxt_pc_s;
               if (!fifo_full) begin
                  req_addr_d = nxt_pc_s;
                  state_d    = REQ;
               end else begin
                  state_d = IDLE;
               end
            end else if (redir_s) begin
               pend_pc_d = redir_tgt_s;
               pend_d    = 1'b1;
               state_d   = STALE;
            end else begin
               state_d = RESP;
            end
         end
         STALE: begin
            if (redir_s) begin
               pend_pc_d = redir_tgt_s;
               pend_d    = 1'b1;
            end else begin
               pend_pc_d = pend_pc_q;
            end
            // A redirect arriving with the stale response is newer than pend_pc
            if (inst_data_ok) begin
               pc_d    = redir_s ? redir_tgt_s : pend_pc_q;
               pend_d  = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = STALE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and PC registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         pend_pc_q  <= {ADDR_W{1'b0}};
         pend_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         pend_pc_q  <= pend_pc_d;
         pend_q     <= pend_d;
      end
   end

   assign inst_req      = (state_q == REQ);
   assign inst_addr     = req_addr_q;
   assign fetch_valid1  = fv1_s;
   assign fetch_valid2  = fv2_s;
   assign fetch_inst1   = inst_rdata1;
   assign fetch_inst2   = inst_rdata2;
   assign fetch_pc      = req_addr_q;
   assign pc_curr       = pc_q;
   assign redirect_pend = pend_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_fetch_seq_ctrl;

   localparam logic [31:0] RST_PC = 32'hbfc00000;

   logic        clk = 1'b0;
   logic        rst;
   logic        is_except, branch_en, branch_taken, flush_all, fifo_full;
   logic [31:0] except_addr, branch_addr, flush_all_addr;
   logic        inst_req, inst_addr_ok, inst_data_ok;
   logic [31:0] inst_addr, inst_rdata1, inst_rdata2;
   logic        fetch_valid1, fetch_valid2;
   logic [31:0] fetch_inst1, fetch_inst2, fetch_pc, pc_curr;
   logic        redirect_pend;

   always #5 clk = ~clk;

   fetch_seq_ctrl dut (
      .clk(clk), .rst(rst),
      .is_except(is_except), .except_addr(except_addr),
      .branch_en(branch_en), .branch_taken(branch_taken), .branch_addr(branch_addr),
      .flush_all(flush_all), .flush_all_addr(flush_all_addr),
      .fifo_full(fifo_full),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .inst_rdata1(inst_rdata1), .inst_rdata2(inst_rdata2),
      .fetch_valid1(fetch_valid1), .fetch_valid2(fetch_valid2),
      .fetch_inst1(fetch_inst1), .fetch_inst2(fetch_inst2),
      .fetch_pc(fetch_pc), .pc_curr(pc_curr), .redirect_pend(redirect_pend)
   );

   int checks = 0;
   int failures = 0;

   // stimulus requests (applied at the next tick)
   logic        s_exc = 1'b0, s_br_en = 1'b0, s_br_tk = 1'b0, s_fl = 1'b0, s_full = 1'b0;
   logic [31:0] s_exc_addr = 32'h0, s_br_addr = 32'h0, s_fl_addr = 32'h0;

   // bus responder
   int          a_lat = 0, d_lat = 0, a_cnt = 0, d_cnt = 0;
   logic        busy = 1'b0, hs_addr = 1'b0, hs_data = 1'b0;
   logic [31:0] bus_addr = 32'h0, hs_addr_val = 32'h0;

   // reference model: at most one transaction, possibly squashed by a redirect
   logic        m_txn, m_acc, m_sq;
   logic [31:0] m_addr, m_pc, m_sqpc;

   // observations from the latest tick
   logic        obs_req, obs_fv1, obs_fv2, obs_pend;
   logic [31:0] obs_addr, obs_fpc, obs_pc;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h13579bdf;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_txn = 1'b0; m_acc = 1'b0; m_sq = 1'b0;
      m_addr = RST_PC; m_pc = RST_PC; m_sqpc = 32'h0;
   endtask

   task automatic get_redir(output logic r, output logic [31:0] t);
      r = s_exc | (s_br_en & s_br_tk) | s_fl;
      t = s_exc ? s_exc_addr : ((s_br_en & s_br_tk) ? s_br_addr : (s_fl ? s_fl_addr : 32'h0));
   endtask

   task automatic tick();
      logic        r, e_req, e_fv1, e_fv2;
      logic [31:0] t, nxt;
      @(negedge clk);
      if (!rst) begin
         busy = 1'b0; a_cnt = 0; d_cnt = 0;
      end else begin
         if (hs_data) busy = 1'b0;
         if (hs_addr) begin busy = 1'b1; d_cnt = 0; a_cnt = 0; bus_addr = hs_addr_val; end
      end
      is_except = s_exc; except_addr = s_exc_addr;
      branch_en = s_br_en; branch_taken = s_br_tk; branch_addr = s_br_addr;
      flush_all = s_fl; flush_all_addr = s_fl_addr; fifo_full = s_full;
      inst_addr_ok = rst && inst_req && (a_cnt >= a_lat);
      if (inst_req) a_cnt++;
      inst_data_ok = busy && (d_cnt >= d_lat);
      if (busy) d_cnt++;
      inst_rdata1 = inst_of(bus_addr);
      inst_rdata2 = inst_of(bus_addr + 32'd4);
      #2;
      get_redir(r, t);
      e_req = m_txn && !m_acc;
      e_fv1 = m_txn && m_acc && !m_sq && inst_data_ok && !r;
      e_fv2 = e_fv1 && !m_addr[2];
      chk("inst_req", inst_req, e_req);
      if (e_req) chk("inst_addr", inst_addr, m_addr);
      chk("fetch_valid1", fetch_valid1, e_fv1);
      chk("fetch_valid2", fetch_valid2, e_fv2);
      if (e_fv1) begin
         chk("fetch_pc", fetch_pc, m_addr);
         chk("fetch_inst1", fetch_inst1, inst_of(m_addr));
         chk("fetch_inst2", fetch_inst2, inst_of(m_addr + 32'd4));
      end
      chk("pc_curr", pc_curr, m_pc);
      chk("redirect_pend", redirect_pend, m_sq);
      obs_req = inst_req; obs_addr = inst_addr; obs_fv1 = fetch_valid1; obs_fv2 = fetch_valid2;
      obs_fpc = fetch_pc; obs_pc = pc_curr; obs_pend = redirect_pend;
      hs_addr = inst_req && inst_addr_ok; hs_addr_val = inst_addr; hs_data = inst_data_ok;
      @(posedge clk);
      if (!rst) begin
         model_reset();
         hs_addr = 1'b0; hs_data = 1'b0;
      end else if (!m_txn) begin
         if (r) m_pc = t;
         else if (!s_full) begin m_txn = 1'b1; m_acc = 1'b0; m_sq = 1'b0; m_addr = m_pc; end
      end else if (!m_acc) begin
         if (r) begin m_sq = 1'b1; m_sqpc = t; end
         if (inst_addr_ok) m_acc = 1'b1;
      end else if (inst_data_ok) begin
         if (m_sq || r) begin
            m_pc = r ? t : m_sqpc; m_sq = 1'b0; m_txn = 1'b0;
         end else begin
            nxt = m_addr + (m_addr[2] ? 32'd4 : 32'd8);
            m_pc = nxt;
            if (!s_full) begin m_addr = nxt; m_acc = 1'b0; end
            else m_txn = 1'b0;
         end
      end else if (r) begin
         m_sq = 1'b1; m_sqpc = t;
      end
   endtask

   task automatic clear_redir();
      s_exc = 1'b0; s_br_en = 1'b0; s_br_tk = 1'b0; s_fl = 1'b0;
   endtask

   task automatic wait_fetch(input string nm);
      int n = 0;
      tick();
      while (!obs_fv1 && n < 40) begin tick(); n++; end
      chk(nm, obs_fv1, 1'b1);
   endtask

   task automatic wait_req(input string nm, output int fv_seen);
      int n = 0;
      fv_seen = 0;
      tick();
      if (obs_fv1) fv_seen++;
      while (!obs_req && n < 40) begin
         tick(); n++;
         if (obs_fv1) fv_seen++;
      end
      chk(nm, obs_req, 1'b1);
   endtask

   initial begin
      int fvs;
      rst = 1'b0;
      is_except = 1'b0; branch_en = 1'b0; branch_taken = 1'b0; flush_all = 1'b0; fifo_full = 1'b0;
      except_addr = 32'h0; branch_addr = 32'h0; flush_all_addr = 32'h0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata1 = 32'h0; inst_rdata2 = 32'h0;
      model_reset();

      tick();
      chk("rst_req", obs_req, 1'b0);
      chk("rst_pc", obs_pc, 32'hbfc00000);
      chk("rst_pend", obs_pend, 1'b0);
      chk("rst_fv1", obs_fv1, 1'b0);
      tick();
      #1 rst = 1'b1;

      // first fetch: two slots, next request 8 bytes on
      wait_fetch("s1_fetch");
      chk("s1_fpc", obs_fpc, 32'hbfc00000);
      chk("s1_fv2", obs_fv2, 1'b1);
      wait_req("s1_req", fvs);
      chk("s1_next_addr", obs_addr, 32'hbfc00008);

      // redirect to an odd word: single slot, then step 4
      s_fl = 1'b1; s_fl_addr = 32'hbfc00004;
      tick(); clear_redir();
      chk("s2_drop", obs_fv1, 1'b0);
      wait_fetch("s2_fetch");
      chk("s2_fpc", obs_fpc, 32'hbfc00004);
      chk("s2_fv2", obs_fv2, 1'b0);
      wait_req("s2_req", fvs);
      chk("s2_next_addr", obs_addr, 32'hbfc00008);

      // branch while waiting for data: response squashed
      d_lat = 3;
      s_br_en = 1'b1; s_br_tk = 1'b1; s_br_addr = 32'h80001000;
      tick(); clear_redir();
      chk("s3_nofetch", obs_fv1, 1'b0);
      tick();
      chk("s3_pend", obs_pend, 1'b1);
      wait_req("s3_req", fvs);
      chk("s3_addr", obs_addr, 32'h80001000);
      chk("s3_dropped", fvs, 0);

      // fifo_full holds the sequencer idle at an unchanged pc
      s_full = 1'b1; d_lat = 0;
      wait_fetch("s6_fetch");
      chk("s6_fpc", obs_fpc, 32'h80001000);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("s6_noreq", obs_req, 1'b0);
         chk("s6_pc", obs_pc, 32'h80001008);
      end
      s_full = 1'b0;
      wait_req("s6_req", fvs);
      chk("s6_addr", obs_addr, 32'h80001008);
      s_full = 1'b1;
      wait_fetch("s6_fetch2");
      tick();

      // exception and branch together: exception wins
      s_exc = 1'b1; s_exc_addr = 32'hbfc00380;
      s_br_en = 1'b1; s_br_tk = 1'b1; s_br_addr = 32'h80002000;
      tick(); clear_redir();
      s_full = 1'b0; a_lat = 3;
      wait_req("s4_req", fvs);
      chk("s4_addr", obs_addr, 32'hbfc00380);

      // branch during a stalled request: address held, response squashed
      s_br_en = 1'b1; s_br_tk = 1'b1; s_br_addr = 32'h80003000;
      tick(); clear_redir();
      chk("s5_hold0", obs_addr, 32'hbfc00380);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!obs_req) break;
         chk("s5_hold", obs_addr, 32'hbfc00380);
      end
      chk("s5_stale_pend", obs_pend, 1'b1);
      a_lat = 0;
      wait_req("s5_req", fvs);
      chk("s5_addr", obs_addr, 32'h80003000);
      chk("s5_dropped", fvs, 0);

      // address wrap at the top of the space
      s_full = 1'b1;
      wait_fetch("s7_fetch0");
      s_fl = 1'b1; s_fl_addr = 32'hfffffffc;
      tick(); clear_redir();
      s_full = 1'b0;
      wait_fetch("s7_fetch");
      chk("s7_fpc", obs_fpc, 32'hfffffffc);
      chk("s7_fv2", obs_fv2, 1'b0);
      wait_req("s7_req", fvs);
      chk("s7_wrap_addr", obs_addr, 32'h00000000);

      // mixed traffic checked against the model
      for (int i = 0; i < 200; i++) begin
         s_exc = ($urandom_range(0, 15) == 0);
         s_br_en = ($urandom_range(0, 3) == 0); s_br_tk = $urandom_range(0, 1) == 1;
         s_fl = ($urandom_range(0, 15) == 0);
         s_exc_addr = 32'($urandom()) & 32'hfffffffc;
         s_br_addr = 32'($urandom()) & 32'hfffffffc;
         s_fl_addr = 32'($urandom()) & 32'hfffffffc;
         s_full = ($urandom_range(0, 4) == 0);
         a_lat = $urandom_range(0, 2); d_lat = $urandom_range(0, 2);
         tick();
      end
      clear_redir(); s_full = 1'b0; a_lat = 0; d_lat = 2;
      wait_req("s8_req", fvs);
      tick();

      // asynchronous reset while a response is outstanding
      @(negedge clk);
      #3 rst = 1'b0;
      model_reset();
      hs_addr = 1'b0; hs_data = 1'b0; busy = 1'b0;
      #1;
      chk("arst_req", inst_req, 1'b0);
      chk("arst_pc", pc_curr, 32'hbfc00000);
      chk("arst_pend", redirect_pend, 1'b0);
      chk("arst_fv1", fetch_valid1, 1'b0);
      tick();
      tick();
      #1 rst = 1'b1;
      wait_req("arst_req2", fvs);
      chk("arst_addr", obs_addr, 32'hbfc00000);
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
